// File: rtl/booth_mul_16bit.sv
// booth_mul_16bit
//   Sequential 16x16 signed multiplier, radix-2 Booth recoding, one
//   add/subtract/skip step per clock. 16 steps per product; a start held
//   high through the DONE cycle restarts immediately (17-clock cadence).
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request; accepted in IDLE or DONE, ignored in RUN
//   A, B   signed multiplicand / multiplier, captured with accepted start
//   busy   high while the 16 Booth steps are in progress
//   done   one-cycle pulse when P is updated
//   P      signed 32-bit product, held until the next product completes

// 17-bit add/sub by control: y = a + b (sub=0) or a - b (sub=1).
// The subtract is done as a + ~b + 1 so a single adder serves both.
module booth_addsub (
    input  logic [16:0] a,
    input  logic [16:0] b,
    input  logic        sub,
    output logic [16:0] y
);
    assign y = a + (b ^ {17{sub}}) + {16'd0, sub};
endmodule

module booth_mul_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] P
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [16:0] m;      // sign-extended multiplicand
    logic [16:0] acc;    // upper partial product, one guard bit wide
    logic [15:0] q;      // multiplier, shifts into the low product half
    logic        q_1;    // Booth guard bit
    logic [4:0]  cnt;

    logic        step_en;
    logic        step_sub;
    logic [16:0] addend;
    logic [16:0] t;
    logic [16:0] acc_n;
    logic [15:0] q_n;

    // {q[0],q_1}: 01 -> +M, 10 -> -M, 00/11 -> skip (add zero).
    always_comb begin
        step_en  = q[0] ^ q_1;
        step_sub = step_en & q[0];
        addend   = step_en ? m : 17'd0;
    end

    booth_addsub u_addsub (
        .a   (acc),
        .b   (addend),
        .sub (step_sub),
        .y   (t)
    );

    // Arithmetic right shift of {T,Q,q_1}.
    always_comb begin
        acc_n = {t[16], t[16:1]};
        q_n   = {t[0], q[15:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            P     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= {A[15], A};
                        acc   <= '0;
                        q     <= B;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_n;
                    q   <= q_n;
                    q_1 <= q[0];
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        // Product taken from post-shift values of the last step.
                        P     <= {acc_n[15:0], q_n};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
